// File: rtl/cpu_out_capture_fifo_if.sv
// cpu_out_capture_fifo_if: capture input and valid/ready read port of the cpu output capture fifo
interface cpu_out_capture_fifo_if #(parameter int DATA_W = 2);
  logic [DATA_W-1:0] cpu_out;
  logic capture_en;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic rd_ready;
  modport master(output cpu_out, capture_en, rd_ready, input rd_data, rd_valid);
  modport slave(input cpu_out, capture_en, rd_ready, output rd_data, rd_valid);
endinterface

// File: rtl/cpu_out_capture_fifo.sv
// cpu_out_capture_fifo: queues cpu output samples (optionally change-only) with sticky drop tracking
module cpu_out_capture_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH = 8,
  parameter int CHANGE_ONLY = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  cpu_out_capture_fifo_if.slave bus,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic overflow,
  output logic [CNT_W-1:0] drop_count,
  input logic clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] last_val;
  logic first_flag, push_req, push, pop, drop;
  always_comb begin
    push_req = bus.capture_en && (CHANGE_ONLY == 0 || first_flag || bus.cpu_out != last_val);
    pop = bus.rd_valid && bus.rd_ready;
    push = push_req && (!full || pop);
    drop = push_req && !push;
  end
  assign bus.rd_valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign bus.rd_data = bus.rd_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.cpu_out;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last_val <= '0;
      first_flag <= 1'b1;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        last_val <= bus.cpu_out;
        first_flag <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= push && !pop ? count + 1'b1 : pop && !push ? count - 1'b1 : count;
      overflow <= clr_ovf ? 1'b0 : drop ? 1'b1 : overflow;
      drop_count <= clr_ovf ? '0 : drop && !(&drop_count) ? drop_count + 1'b1 : drop_count;
    end
endmodule

// File: tb/tb_cpu_out_capture_fifo.sv
// tb_cpu_out_capture_fifo: directed checks of a change-only and an every-cycle capture fifo
module tb_cpu_out_capture_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1, clr_ovf = 1'b0, capture_en = 1'b0, rd_ready = 1'b0;
  logic [1:0] cpu_out = '0;
  logic [3:0] cnt_a, cnt_b;
  logic full_a, full_b, ovf_a, ovf_b;
  logic [7:0] dc_a, dc_b;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  cpu_out_capture_fifo_if #(.DATA_W(2)) ia();
  cpu_out_capture_fifo_if #(.DATA_W(2)) ib();
  assign ia.cpu_out = cpu_out;
  assign ia.capture_en = capture_en;
  assign ia.rd_ready = rd_ready;
  assign ib.cpu_out = cpu_out;
  assign ib.capture_en = capture_en;
  assign ib.rd_ready = rd_ready;
  cpu_out_capture_fifo #(.DATA_W(2), .DEPTH(8), .CHANGE_ONLY(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ia), .count(cnt_a), .full(full_a),
    .overflow(ovf_a), .drop_count(dc_a), .clr_ovf(clr_ovf));
  cpu_out_capture_fifo #(.DATA_W(2), .DEPTH(8), .CHANGE_ONLY(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .bus(ib), .count(cnt_b), .full(full_b),
    .overflow(ovf_b), .drop_count(dc_b), .clr_ovf(clr_ovf));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] seq2 [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
    logic [1:0] seq3 [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] exp4 [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [1:0] seq6 [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    repeat (3) step();
    chk("rst_valid", ia.rd_valid, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_drop", dc_a, 0);
    chk("rst_data", ia.rd_data, 0);
    reset = 1'b0;
    capture_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_out = seq2[i];
      step();
    end
    chk("chg_count", cnt_a, 3);
    chk("all_count", cnt_b, 6);
    capture_en = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("chg_pop%0d", i), ia.rd_data, i + 1);
      step();
    end
    chk("chg_empty", ia.rd_valid, 0);
    chk("chg_count0", cnt_a, 0);
    reset = 1'b1;
    rd_ready = 1'b0;
    step();
    reset = 1'b0;
    capture_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_out = seq3[i];
      step();
    end
    chk("ovf_full", full_b, 1);
    chk("ovf_count", cnt_b, 8);
    chk("ovf_flag", ovf_b, 1);
    chk("ovf_drops", dc_b, 2);
    chk("ovf_head", ib.rd_data, 0);
    cpu_out = 2'd3;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", ovf_b, 0);
    chk("clr_drops", dc_b, 0);
    chk("clr_count", cnt_b, 8);
    cpu_out = 2'd2;
    rd_ready = 1'b1;
    step();
    chk("fpp_count", cnt_b, 8);
    chk("fpp_head", ib.rd_data, 1);
    chk("fpp_ovf", ovf_b, 0);
    capture_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fpp_pop%0d", i), ib.rd_data, exp4[i]);
      step();
    end
    chk("fpp_empty", cnt_b, 0);
    reset = 1'b1;
    rd_ready = 1'b0;
    step();
    reset = 1'b0;
    capture_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_out = (i % 2 == 1) ? 2'd2 : 2'd1;
      step();
    end
    chk("lv_full", cnt_a, 8);
    cpu_out = 2'd3;
    step();
    chk("lv_drop_count", cnt_a, 8);
    chk("lv_ovf", ovf_a, 1);
    chk("lv_drops", dc_a, 1);
    capture_en = 1'b0;
    rd_ready = 1'b1;
    step();
    chk("lv_pop", cnt_a, 7);
    capture_en = 1'b1;
    rd_ready = 1'b0;
    step();
    chk("lv_repush", cnt_a, 8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_out = 2'd2;
    rd_ready = 1'b1;
    #1;
    chk("emp_nopass", ia.rd_valid, 0);
    step();
    chk("emp_valid", ia.rd_valid, 1);
    chk("emp_data", ia.rd_data, 2);
    chk("emp_count", cnt_a, 1);
    capture_en = 1'b0;
    rd_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    capture_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_out = seq6[i];
      step();
    end
    chk("ar_count5", cnt_a, 5);
    capture_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count0", cnt_a, 0);
    chk("ar_valid0", ia.rd_valid, 0);
    step();
    reset = 1'b0;
    capture_en = 1'b1;
    cpu_out = 2'd0;
    step();
    chk("ar_first", cnt_a, 1);
    chk("ar_fvalid", ia.rd_valid, 1);
    chk("ar_fdata", ia.rd_data, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
